// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps one instruction-memory request outstanding and handles stalls, redirects and bubbles.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] PC_Branch,
    input  logic        IF_ID_write,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_ID,
    output logic [31:0] INSTRUCTION_ID
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] instr_id_q, instr_id_d;

    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] target;
    logic [31:0] pc_inc;

    // Redirect targets are word-aligned so a misaligned fetch can never be issued.
    assign target = PC_Branch & ~32'h0000_0003;
    assign pc_inc = pc_q + 32'd4;

    assign imem_req  = (state_q == S_REQ) & ~PCSrc & reset;
    assign imem_addr = pc_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        deliver       = 1'b0;
        deliver_instr = buf_q;

        unique case (state_q)
            S_REQ: begin
                if (PCSrc) pc_d = target;
                else       state_d = S_WAIT;
            end
            S_WAIT: begin
                if (PCSrc) begin
                    pc_d    = target;
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    if (IF_ID_write) begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata;
                        pc_d          = pc_inc;
                        state_d       = S_REQ;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (PCSrc) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (IF_ID_write) begin
                    deliver = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                // The stale response must drain before a new request; the newest target wins.
                if (PCSrc)       pc_d    = target;
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // Flush beats stall, stall beats load, and an empty slot becomes a bubble.
        if (PCSrc) begin
            pc_id_d    = 32'h0;
            instr_id_d = NOP_INSTR;
        end else if (!IF_ID_write) begin
            pc_id_d    = pc_id_q;
            instr_id_d = instr_id_q;
        end else if (deliver) begin
            pc_id_d    = pc_q;
            instr_id_d = deliver_instr;
        end else begin
            pc_id_d    = 32'h0;
            instr_id_d = NOP_INSTR;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            buf_q      <= 32'h0;
            pc_id_q    <= 32'h0;
            instr_id_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            pc_id_q    <= pc_id_d;
            instr_id_q <= instr_id_d;
        end
    end

    assign PC_ID          = pc_id_q;
    assign INSTRUCTION_ID = instr_id_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a latency-configurable memory model plus a
// transaction-level reference (outstanding request, stale flag, one-entry buffer).
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc;
    logic [31:0] PC_Branch;
    logic        IF_ID_write;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_ID;
    logic [31:0] INSTRUCTION_ID;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc         (PCSrc),
        .PC_Branch     (PC_Branch),
        .IF_ID_write   (IF_ID_write),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .PC_ID         (PC_ID),
        .INSTRUCTION_ID(INSTRUCTION_ID)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the fetch unit knows, not how it encodes it.
    logic        m_known = 1'b0;
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_stale;
    logic        m_bufv;
    logic [31:0] m_buf;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;

    // Memory environment: one response after a programmable delay.
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC001_D00D;
    endfunction

    task automatic model_step();
        logic        deliver;
        logic [31:0] d_instr;
        logic [31:0] d_pc;
        deliver = 1'b0;
        d_instr = 32'h0;
        d_pc    = m_pc;
        if (!reset) begin
            m_known    = 1'b1;
            m_pc       = RST_PC;
            m_out      = 1'b0;
            m_stale    = 1'b0;
            m_bufv     = 1'b0;
            m_buf      = 32'h0;
            m_id_pc    = 32'h0;
            m_id_instr = NOP;
            return;
        end
        if (PCSrc) begin
            m_bufv = 1'b0;
            m_pc   = {PC_Branch[31:2], 2'b00};
            if (m_out) begin
                if (imem_rvalid) begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end
        end else if (m_out && imem_rvalid) begin
            m_out = 1'b0;
            if (m_stale) begin
                m_stale = 1'b0;
            end else if (IF_ID_write) begin
                deliver = 1'b1;
                d_instr = imem_rdata;
                m_pc    = m_pc + 32'd4;
            end else begin
                m_bufv = 1'b1;
                m_buf  = imem_rdata;
            end
        end else if (m_bufv) begin
            if (IF_ID_write) begin
                deliver = 1'b1;
                d_instr = m_buf;
                m_bufv  = 1'b0;
                m_pc    = m_pc + 32'd4;
            end
        end else if (!m_out) begin
            m_out   = 1'b1;
            m_stale = 1'b0;
        end

        if (PCSrc) begin
            m_id_pc    = 32'h0;
            m_id_instr = NOP;
        end else if (!IF_ID_write) begin
            // hold
        end else if (deliver) begin
            m_id_pc    = d_pc;
            m_id_instr = d_instr;
        end else begin
            m_id_pc    = 32'h0;
            m_id_instr = NOP;
        end
    endtask

    task automatic run(input int rst_cycles, input int cycles, input int p_br, input int p_stall,
                       input int lat_lo, input int lat_hi, input int p_rst, input int p_spur);
        logic exp_req;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            reset       = !((c < rst_cycles) || ($urandom_range(99) < p_rst));
            PCSrc       = ($urandom_range(99) < p_br);
            PC_Branch   = ($urandom_range(3) == 0) ? (32'hFFFF_FFFC | ($urandom & 32'h3)) : $urandom;
            IF_ID_write = !($urandom_range(99) < p_stall);
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (!reset) begin
                mem_cnt = 0;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(mem_addr);
                end
            end else if ($urandom_range(99) < p_spur) begin
                imem_rvalid = 1'b1;
            end
            #1;
            if (m_known) begin
                exp_req = reset && !m_out && !m_bufv && !PCSrc;
                check("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
                check("imem_addr", imem_addr, m_pc);
                check("PC_ID", PC_ID, m_id_pc);
                check("INSTRUCTION_ID", INSTRUCTION_ID, m_id_instr);
            end
            if (imem_req === 1'b1) begin
                mem_cnt  = $urandom_range(lat_hi, lat_lo);
                mem_addr = imem_addr;
            end
            model_step();
        end
    endtask

    initial begin
        reset       = 1'b0;
        PCSrc       = 1'b0;
        PC_Branch   = 32'h0;
        IF_ID_write = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        // reset, then straight-line fetch through the 32-bit wrap
        run(3, 40, 0, 0, 1, 1, 0, 0);
        // heavy stalls with spurious rvalid
        run(0, 300, 0, 40, 1, 2, 0, 10);
        // frequent redirects, variable latency
        run(0, 300, 15, 0, 1, 4, 0, 0);
        // slow memory
        run(0, 200, 0, 0, 4, 4, 0, 0);
        // redirects combined with stalls
        run(0, 400, 30, 50, 1, 3, 0, 5);
        // everything mixed, including mid-request resets
        run(0, 1000, 10, 30, 1, 5, 1, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
